ksa: RTL and testbench
======================

KSA -- requirements
Module: ksa

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: en  input  1  start request; sampled only while rdy=1.
REQ-004 SHALL have port: rdy  output  1  1 = idle and ready to accept en; 0 = busy.
REQ-005 SHALL have port: key  input  24  cipher key; key[23:16] = byte 0, key[15:8] = byte 1, key[7:0] = byte 2.
REQ-006 SHALL have port: addr  output  8  S-memory address.
REQ-007 SHALL have port: rddata  input  8  S-memory read data.
REQ-008 SHALL have port: wrdata  output  8  S-memory write data.
REQ-009 SHALL have port: wren  output  1  S-memory write enable.
REQ-010 SHALL have no parameters.

Function
REQ-011 SHALL drive a 256x8 single-port synchronous RAM (s_mem).
- Address is registered on the clock edge; rddata is valid the cycle after addr is presented.
- A write with wren=1 takes effect at the clock edge.
REQ-012 SHALL assume S already holds the identity permutation (S[i]=i) before start; ksa SHALL NOT initialize S.
REQ-013 SHALL latch key on the en-accept edge; key changes during a run SHALL have no effect.
REQ-014 SHALL execute the RC4 key schedule for i = 0..255, with j starting at 0:
- j = (j + S[i] + keybyte[i mod 3]) mod 256, 8-bit wrap.
- Swap S[i] and S[j].
REQ-015 SHALL use the states IDLE, RD_I, RD_J, WR_I, WR_J.
- IDLE: rdy=1, wren=0. en=1 -> RD_I with i=0, j=0.
- RD_I: addr=i -> RD_J.
- RD_J: si <= rddata; j <= (j + rddata + keybyte) mod 256; addr = that new j -> WR_I.
- WR_I: addr=i, wrdata=rddata (S[j]), wren=1 -> WR_J.
- WR_J: addr=j, wrdata=si, wren=1; if i=255 -> IDLE, else i <= i+1 and -> RD_I.
REQ-016 SHALL issue exactly 2 writes per index, 512 total per run, including when i=j (both writes still occur; the result is unchanged).
REQ-017 SHALL take 4 cycles per index; rdy SHALL return to 1 no more than 1030 cycles after the en-accept edge.
REQ-018 SHALL deassert rdy on the cycle after en is accepted and hold it at 0 until return to IDLE.
REQ-019 SHALL ignore en while busy; en held high across completion SHALL start a new run.
REQ-020 SHALL keep wren=0 whenever rdy=1.
REQ-021 SHALL use 8-bit counters: i (0..255) and j (mod 256).

Reset
REQ-022 SHALL force the following asynchronously while rst=1: state IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0.
REQ-023 SHALL abort a run in progress when rst is asserted mid-run.
- No further writes are made.
- Memory keeps its partial contents.
- The next en starts a fresh run from i=0.

Verification
REQ-024 SHALL pass: S preloaded with identity, key=24'h000155, en pulsed 1 cycle.
- Exactly 512 wren cycles.
- rdy=1 within 1200 cycles.
- S equals a software RC4 KSA with key bytes {00,01,55}.
- wren=0 for 3 cycles after rdy.
REQ-025 SHALL pass: key=24'h000000 on identity S -> S equals the software KSA for key {00,00,00}; 512 writes.
REQ-026 SHALL pass: en re-pulsed while busy -> ignored; still 512 writes and a correct S.
REQ-027 SHALL pass: rst asserted around index 100 -> rdy=1 and wren=0 immediately.
- After reloading identity S and pulsing en, the final S is correct.
REQ-028 SHALL pass: key changed on the cycle after en accept -> the result uses the originally latched key.

Source files
------------

// File: rtl/ksa_if.sv
// Bus bundle between the RC4 key-schedule engine, its controller and the S memory.
// The master side belongs to the engine; the slave side to the controller/memory.
interface ksa_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    modport master (
        input  en,
        input  key,
        input  rddata,
        output rdy,
        output addr,
        output wrdata,
        output wren
    );

    modport slave (
        output en,
        output key,
        output rddata,
        input  rdy,
        input  addr,
        input  wrdata,
        input  wren
    );
endinterface

// File: rtl/ksa.sv
// RC4 key-scheduling engine: permutes an identity-loaded 256x8 S memory in place,
// four cycles per index (read S[i], read S[j], write S[i], write S[j]).
module ksa (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  addr,
    input  logic [7:0]  rddata,
    output logic [7:0]  wrdata,
    output logic        wren
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_I = 3'd1,
        RD_J = 3'd2,
        WR_I = 3'd3,
        WR_J = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_rdy;
    logic        r_wren;
    logic [7:0]  r_i;
    logic [7:0]  r_j;
    logic [7:0]  r_si;
    logic [1:0]  r_kidx;
    logic [23:0] r_key;

    logic [7:0]  w_kb;
    logic [7:0]  w_j_next;
    logic [7:0]  w_addr;
    logic [7:0]  w_wrdata;

    // Key byte selected by i mod 3, tracked with a small wrap counter.
    always_comb begin
        w_kb = 8'd0;
        case (r_kidx)
            2'd0:    w_kb = r_key[23:16];
            2'd1:    w_kb = r_key[15:8];
            default: w_kb = r_key[7:0];
        endcase
    end

    assign w_j_next = r_j + rddata + w_kb;

    // addr/wrdata must follow rddata in the same cycle to keep four cycles per index.
    always_comb begin
        w_addr   = 8'd0;
        w_wrdata = 8'd0;
        case (r_state)
            RD_I: begin
                w_addr   = r_i;
                w_wrdata = 8'd0;
            end
            RD_J: begin
                w_addr   = w_j_next;
                w_wrdata = 8'd0;
            end
            WR_I: begin
                w_addr   = r_i;
                w_wrdata = rddata;
            end
            WR_J: begin
                w_addr   = r_j;
                w_wrdata = r_si;
            end
            default: begin
                w_addr   = 8'd0;
                w_wrdata = 8'd0;
            end
        endcase
    end

    // Sequencer: index/j bookkeeping, key latch, ready and write strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_rdy   <= 1'b1;
            r_wren  <= 1'b0;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_si    <= 8'd0;
            r_kidx  <= 2'd0;
            r_key   <= 24'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= RD_I;
                        r_rdy   <= 1'b0;
                        r_i     <= 8'd0;
                        r_j     <= 8'd0;
                        r_kidx  <= 2'd0;
                        r_key   <= key;
                    end
                end
                RD_I: begin
                    r_state <= RD_J;
                end
                RD_J: begin
                    r_si    <= rddata;
                    r_j     <= w_j_next;
                    r_wren  <= 1'b1;
                    r_state <= WR_I;
                end
                WR_I: begin
                    r_state <= WR_J;
                end
                WR_J: begin
                    r_wren <= 1'b0;
                    if (r_i == 8'd255) begin
                        r_state <= IDLE;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_i     <= r_i + 8'd1;
                        r_kidx  <= (r_kidx == 2'd2) ? 2'd0 : (r_kidx + 2'd1);
                        r_state <= RD_I;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b1;
                    r_wren  <= 1'b0;
                end
            endcase
        end
    end

    assign rdy    = r_rdy;
    assign wren   = r_wren;
    assign addr   = w_addr;
    assign wrdata = w_wrdata;

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: behavioural S memory, software RC4 key schedule as reference,
// table of runs plus abort and back-to-back sequences.
module tb_ksa;

    typedef struct {
        logic [23:0] key;
        bit          repulse;
        bit          kchg;
        int          exp_writes;
        int          exp_lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_id = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] exp_s [256];
    int         wr_total = 0;
    int         viol = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       tbl [4];

    ksa_if bus ();

    ksa dut (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .rdy    (bus.rdy),
        .key    (bus.key),
        .addr   (bus.addr),
        .rddata (bus.rddata),
        .wrdata (bus.wrdata),
        .wren   (bus.wren)
    );

    always #5 clk = ~clk;

    // Synchronous single-port S memory with registered read address.
    always @(posedge clk) begin
        if (load_id) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (bus.wren) begin
            mem[bus.addr] <= bus.wrdata;
        end
        bus.rddata <= mem[bus.addr];
    end

    always @(posedge clk) begin
        if (bus.wren) wr_total <= wr_total + 1;
    end

    always @(negedge clk) begin
        if (!rst && bus.rdy && bus.wren) viol <= viol + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    endtask

    task automatic model_run(input logic [23:0] k);
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j = j + exp_s[i] + kb;
            t = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic load_identity();
        @(negedge clk);
        load_id = 1'b1;
        @(negedge clk);
        load_id = 1'b0;
    endtask

    task automatic compare_s(input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== exp_s[k]) bad++;
        end
        check(name, bad, 0);
    endtask

    // Counts negedges until rdy is seen high; cyc=1 is the negedge right after the accept edge.
    task automatic wait_rdy(input bit repulse, output int cyc);
        cyc = 1;
        while (!bus.rdy && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (repulse && cyc == 50) bus.en = 1'b1;
            if (repulse && cyc == 53) bus.en = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int w0;
        int cyc;
        int quiet;
        @(negedge clk);
        bus.key = v.key;
        bus.en  = 1'b1;
        w0 = wr_total;
        @(negedge clk);
        bus.en = 1'b0;
        check({tag, "_rdy_drop"}, bus.rdy, 1'b0);
        if (v.kchg) bus.key = ~v.key;
        wait_rdy(v.repulse, cyc);
        check({tag, "_done"}, bus.rdy, 1'b1);
        check({tag, "_latency"}, cyc - 1, v.exp_lat);
        check({tag, "_writes"}, wr_total - w0, v.exp_writes);
        quiet = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.wren !== 1'b0) quiet++;
        end
        check({tag, "_wren_quiet"}, quiet, 0);
        compare_s({tag, "_s"});
    endtask

    initial begin
        int w0;
        int cyc;
        tbl[0] = '{key: 24'h000155, repulse: 1'b0, kchg: 1'b0, exp_writes: 512, exp_lat: 1024};
        tbl[1] = '{key: 24'h000000, repulse: 1'b0, kchg: 1'b0, exp_writes: 512, exp_lat: 1024};
        tbl[2] = '{key: 24'hA5C3FF, repulse: 1'b1, kchg: 1'b0, exp_writes: 512, exp_lat: 1024};
        tbl[3] = '{key: 24'h123456, repulse: 1'b0, kchg: 1'b1, exp_writes: 512, exp_lat: 1024};

        bus.en  = 1'b0;
        bus.key = 24'd0;
        repeat (3) @(negedge clk);
        check("rst_rdy", bus.rdy, 1'b1);
        check("rst_wren", bus.wren, 1'b0);
        check("rst_addr", bus.addr, 8'd0);
        check("rst_wrdata", bus.wrdata, 8'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load_identity();
            model_reset();
            model_run(tbl[v].key);
            run_vec(tbl[v], $sformatf("vec%0d", v));
        end

        // Abort around index 100, then a fresh run must still produce the right permutation.
        load_identity();
        @(negedge clk);
        bus.key = 24'h000155;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (400) @(negedge clk);
        check("mid_busy", bus.rdy, 1'b0);
        rst = 1'b1;
        #1;
        check("abort_rdy", bus.rdy, 1'b1);
        check("abort_wren", bus.wren, 1'b0);
        w0 = wr_total;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_no_writes", wr_total - w0, 0);
        check("abort_idle", bus.rdy, 1'b1);
        load_identity();
        model_reset();
        model_run(24'h000155);
        run_vec(tbl[0], "after_abort");

        // en held high across completion restarts immediately on the permuted S.
        load_identity();
        model_reset();
        model_run(24'h0A0B0C);
        model_run(24'h0A0B0C);
        @(negedge clk);
        bus.key = 24'h0A0B0C;
        bus.en  = 1'b1;
        w0 = wr_total;
        @(negedge clk);
        wait_rdy(1'b0, cyc);
        check("held_first_done", bus.rdy, 1'b1);
        @(negedge clk);
        check("held_restart", bus.rdy, 1'b0);
        bus.en = 1'b0;
        wait_rdy(1'b0, cyc);
        check("held_second_done", bus.rdy, 1'b1);
        check("held_writes", wr_total - w0, 1024);
        compare_s("held_s");

        check("wren_while_rdy", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
